// File: rtl/sc_regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sc_regbank_pkg
// Description : Shared types and default sizes for the general-register
//               bank write-port controller and its round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sc_regbank_pkg;

  // Default geometry of the register bank
  localparam int DEF_DATAWIDTH = 32;
  localparam int DEF_NUM_REGS  = 8;
  localparam int DEF_ADDR_W    = 3;

  // Write-controller sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } regbankState_t;

  // One-hot grant encoding: bit 0 is the writeback port, bit 1 the loader port
  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_WB   = 2'b01,
    GNT_LD   = 2'b10
  } grant_t;

endpackage : sc_regbank_pkg
`default_nettype wire

// File: rtl/sc_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : sc_rr_arb2
// Description : Two-way round-robin arbiter. Grant is combinational from the
//               request vector and the fairness pointer; the pointer only
//               moves when the caller accepts a grant via update.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_rr_arb2
  import sc_regbank_pkg::*;
(
  input  logic       SC_RegGENERAL_CLOCK_50,
  input  logic       SC_RegGENERAL_RESET_InHigh,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // High when the loader port should win the next contested grant
  logic r_favourLd;

  // Pick a winner: a lone requester always wins, a tie goes to the pointer
  always_comb begin
    grant = GNT_NONE;
    case (req)
      2'b01:   grant = GNT_WB;
      2'b10:   grant = GNT_LD;
      2'b11:   grant = r_favourLd ? GNT_LD : GNT_WB;
      default: grant = GNT_NONE;
    endcase
  end

  // Move the pointer away from whoever was just granted
  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
    if (SC_RegGENERAL_RESET_InHigh) begin
      r_favourLd <= 1'b0;
    end else if (update && (grant != GNT_NONE)) begin
      r_favourLd <= (grant == GNT_WB);
    end
  end

endmodule : sc_rr_arb2
`default_nettype wire

// File: rtl/sc_regbank_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sc_regbank_write_ctrl
// Description : Write-port controller for the general-register bank. Shares
//               the C-bus write path between the ALU writeback and the
//               loader/debug port, and sequences a one-register-per-cycle
//               clear sweep. Every output comes straight from a flop.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_regbank_write_ctrl
  import sc_regbank_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                 SC_RegGENERAL_CLOCK_50,
  input  logic                 SC_RegGENERAL_RESET_InHigh,
  input  logic                 wb_req_i,
  input  logic [ADDR_W-1:0]    wb_addr_i,
  input  logic [DATAWIDTH-1:0] wb_data_i,
  output logic                 wb_ack_o,
  input  logic                 ld_req_i,
  input  logic [ADDR_W-1:0]    ld_addr_i,
  input  logic [DATAWIDTH-1:0] ld_data_i,
  output logic                 ld_ack_o,
  input  logic                 clr_all_i,
  output logic                 clr_busy_o,
  output logic                 err_o,
  output logic [NUM_REGS-1:0]  deco_c_n_o,
  output logic [NUM_REGS-1:0]  clear_n_o,
  output logic [DATAWIDTH-1:0] data_bus_o
);

  // Range limit for incoming addresses, one bit wider so NUM_REGS = 2^ADDR_W fits
  localparam logic [ADDR_W:0]       c_numRegs = (ADDR_W+1)'(NUM_REGS);
  // Index of the final register visited by the clear sweep
  localparam logic [ADDR_W-1:0]     c_lastIdx = ADDR_W'(NUM_REGS-1);
  // Single set bit used to build the per-register strobes
  localparam logic [NUM_REGS-1:0]   c_oneHot0 = NUM_REGS'(1);

  regbankState_t          r_state;
  regbankState_t          w_nextState;

  logic [1:0]             w_gnt;
  logic                   w_gntUpdate;
  logic [ADDR_W-1:0]      w_selAddr;
  logic [DATAWIDTH-1:0]   w_selData;
  logic                   w_selInRange;

  logic                   r_pending;
  logic                   w_nextPending;
  logic [ADDR_W-1:0]      r_clrCnt;
  logic [ADDR_W-1:0]      w_nextClrCnt;

  logic [NUM_REGS-1:0]    r_decoN;
  logic [NUM_REGS-1:0]    w_nextDecoN;
  logic [NUM_REGS-1:0]    r_clearN;
  logic [NUM_REGS-1:0]    w_nextClearN;
  logic [DATAWIDTH-1:0]   r_dataBus;
  logic [DATAWIDTH-1:0]   w_nextDataBus;
  logic                   r_wbAck;
  logic                   w_nextWbAck;
  logic                   r_ldAck;
  logic                   w_nextLdAck;
  logic                   r_err;
  logic                   w_nextErr;
  logic                   r_busy;
  logic                   w_nextBusy;

  sc_rr_arb2 u_arb (
    .SC_RegGENERAL_CLOCK_50     (SC_RegGENERAL_CLOCK_50),
    .SC_RegGENERAL_RESET_InHigh (SC_RegGENERAL_RESET_InHigh),
    .req                        ({ld_req_i, wb_req_i}),
    .update                     (w_gntUpdate),
    .grant                      (w_gnt)
  );

  // Route the winning requester's address/data toward the write path
  assign w_selAddr    = (w_gnt == GNT_LD) ? ld_addr_i : wb_addr_i;
  assign w_selData    = (w_gnt == GNT_LD) ? ld_data_i : wb_data_i;
  assign w_selInRange = ({1'b0, w_selAddr} < c_numRegs);

  // Next state and next registered outputs; strobes default to inactive
  always_comb begin
    w_nextState   = r_state;
    w_nextPending = r_pending;
    w_nextClrCnt  = r_clrCnt;
    w_nextDecoN   = '1;
    w_nextClearN  = '1;
    w_nextDataBus = r_dataBus;
    w_nextWbAck   = 1'b0;
    w_nextLdAck   = 1'b0;
    w_nextErr     = 1'b0;
    w_gntUpdate   = 1'b0;

    case (r_state)
      IDLE: begin
        // A pending or fresh clear outranks any waiting write
        if (r_pending || clr_all_i) begin
          w_nextPending = 1'b1;
          w_nextState   = CLEAR;
        end else if (w_gnt != GNT_NONE) begin
          w_gntUpdate = 1'b1;
          w_nextState = WRITE;
          w_nextWbAck = (w_gnt == GNT_WB);
          w_nextLdAck = (w_gnt == GNT_LD);
          if (w_selInRange) begin
            w_nextDecoN   = ~(c_oneHot0 << w_selAddr);
            w_nextDataBus = w_selData;
          end else begin
            // Out-of-range target: acknowledge so the requester moves on, but flag it
            w_nextErr = 1'b1;
          end
        end
      end

      WRITE: begin
        // Write strobe is live this cycle; a clear arriving now is deferred
        if (clr_all_i) begin
          w_nextPending = 1'b1;
        end
        w_nextState = IDLE;
      end

      CLEAR: begin
        // Fresh clr_all_i pulses are ignored here; the sweep is not restarted
        w_nextClearN = ~(c_oneHot0 << r_clrCnt);
        if (r_clrCnt == c_lastIdx) begin
          w_nextClrCnt  = '0;
          w_nextPending = 1'b0;
          w_nextState   = IDLE;
        end else begin
          w_nextClrCnt = r_clrCnt + ADDR_W'(1);
        end
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase

    // Busy spans the pending window plus the final clear strobe cycle
    w_nextBusy = w_nextPending || ((r_state == CLEAR) && (r_clrCnt == c_lastIdx));
  end

  // State, sweep bookkeeping and all output flops
  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
    if (SC_RegGENERAL_RESET_InHigh) begin
      r_state   <= IDLE;
      r_pending <= 1'b0;
      r_clrCnt  <= '0;
      r_decoN   <= '1;
      r_clearN  <= '1;
      r_dataBus <= '0;
      r_wbAck   <= 1'b0;
      r_ldAck   <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_pending <= w_nextPending;
      r_clrCnt  <= w_nextClrCnt;
      r_decoN   <= w_nextDecoN;
      r_clearN  <= w_nextClearN;
      r_dataBus <= w_nextDataBus;
      r_wbAck   <= w_nextWbAck;
      r_ldAck   <= w_nextLdAck;
      r_err     <= w_nextErr;
      r_busy    <= w_nextBusy;
    end
  end

  assign wb_ack_o   = r_wbAck;
  assign ld_ack_o   = r_ldAck;
  assign err_o      = r_err;
  assign clr_busy_o = r_busy;
  assign deco_c_n_o = r_decoN;
  assign clear_n_o  = r_clearN;
  assign data_bus_o = r_dataBus;

endmodule : sc_regbank_write_ctrl
`default_nettype wire

// File: tb/tb_sc_regbank_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_regbank_write_ctrl
// Description : Directed self-checking bench for sc_regbank_write_ctrl. An
//               8-register instance carries most scenarios; a 6-register
//               instance on the same inputs covers the out-of-range path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_regbank_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wbReq = 1'b0;
  logic        ldReq = 1'b0;
  logic        clrAll = 1'b0;
  logic [2:0]  wbAddr = '0;
  logic [2:0]  ldAddr = '0;
  logic [31:0] wbData = '0;
  logic [31:0] ldData = '0;

  logic        wbAck8, ldAck8, busy8, err8;
  logic [7:0]  deco8, clear8;
  logic [31:0] bus8;
  logic        wbAck6, ldAck6, busy6, err6;
  logic [5:0]  deco6, clear6;
  logic [31:0] bus6;

  int nPass  = 0;
  int nTotal = 0;

  // 50 MHz clock
  always #10 clk = ~clk;

  sc_regbank_write_ctrl #(.DATAWIDTH(32), .NUM_REGS(8), .ADDR_W(3)) dut8 (
    .SC_RegGENERAL_CLOCK_50     (clk),
    .SC_RegGENERAL_RESET_InHigh (rst),
    .wb_req_i   (wbReq),  .wb_addr_i (wbAddr), .wb_data_i (wbData), .wb_ack_o (wbAck8),
    .ld_req_i   (ldReq),  .ld_addr_i (ldAddr), .ld_data_i (ldData), .ld_ack_o (ldAck8),
    .clr_all_i  (clrAll), .clr_busy_o (busy8), .err_o (err8),
    .deco_c_n_o (deco8),  .clear_n_o (clear8), .data_bus_o (bus8)
  );

  sc_regbank_write_ctrl #(.DATAWIDTH(32), .NUM_REGS(6), .ADDR_W(3)) dut6 (
    .SC_RegGENERAL_CLOCK_50     (clk),
    .SC_RegGENERAL_RESET_InHigh (rst),
    .wb_req_i   (wbReq),  .wb_addr_i (wbAddr), .wb_data_i (wbData), .wb_ack_o (wbAck6),
    .ld_req_i   (ldReq),  .ld_addr_i (ldAddr), .ld_data_i (ldData), .ld_ack_o (ldAck6),
    .clr_all_i  (clrAll), .clr_busy_o (busy6), .err_o (err6),
    .deco_c_n_o (deco6),  .clear_n_o (clear6), .data_bus_o (bus6)
  );

  // Write strobe and clear strobe must never overlap; at most one write strobe low
  always @(negedge clk) begin
    if (!rst) begin
      nTotal++;
      if (((~deco8 & ~clear8) != 8'h00) || ((~deco6 & ~clear6) != 6'h00) ||
          ($countones(~deco8) > 1) || ($countones(~deco6) > 1))
        $display("FAIL invariant: deco8=%h clear8=%h deco6=%h clear6=%h, required no overlap and at most one deco low",
                 deco8, clear8, deco6, clear6);
      else
        nPass++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; wbReq = 1'b0; ldReq = 1'b0; clrAll = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    nTotal++;
    if ({deco8, clear8, bus8} !== {8'hFF, 8'hFF, 32'h0}) begin
      $display("FAIL reset_vectors: deco=%h clear=%h bus=%h, required FF FF 00000000", deco8, clear8, bus8);
    end else nPass++;
    nTotal++;
    if ({wbAck8, ldAck8, err8, busy8} !== 4'b0000) begin
      $display("FAIL reset_flags: wbAck=%b ldAck=%b err=%b busy=%b, required all 0", wbAck8, ldAck8, err8, busy8);
    end else nPass++;
    nTotal++;
    if ({deco6, clear6} !== {6'h3F, 6'h3F}) begin
      $display("FAIL reset_dut6: deco=%h clear=%h, required 3F 3F", deco6, clear6);
    end else nPass++;
    rst = 1'b0;
    tick();
    nTotal++;
    if ({deco8, clear8, busy8, wbAck8, ldAck8} !== {8'hFF, 8'hFF, 3'b000}) begin
      $display("FAIL idle_after_reset: deco=%h clear=%h busy=%b, required FF FF 0", deco8, clear8, busy8);
    end else nPass++;
  endtask

  task automatic test_single_write();
    doReset();
    wbReq = 1'b1; wbAddr = 3'd3; wbData = 32'hDEADBEEF;
    tick();
    nTotal++;
    if ({deco8, bus8, wbAck8, ldAck8, err8} !== {8'hF7, 32'hDEADBEEF, 3'b100}) begin
      $display("FAIL single_write: deco=%h bus=%h wbAck=%b ldAck=%b err=%b, required F7 DEADBEEF 1 0 0",
               deco8, bus8, wbAck8, ldAck8, err8);
    end else nPass++;
    wbReq = 1'b0;
    tick();
    nTotal++;
    if ({deco8, wbAck8} !== {8'hFF, 1'b0}) begin
      $display("FAIL single_write_one_cycle: deco=%h wbAck=%b, required FF 0", deco8, wbAck8);
    end else nPass++;
    tick();
    nTotal++;
    if ({deco8, wbAck8} !== {8'hFF, 1'b0}) begin
      $display("FAIL single_write_no_repeat: deco=%h wbAck=%b, required FF 0", deco8, wbAck8);
    end else nPass++;
  endtask

  task automatic test_round_robin();
    logic       expWb, expLd;
    logic [7:0] expDeco;
    doReset();
    wbReq = 1'b1; wbAddr = 3'd1; wbData = 32'hAAAA0001;
    ldReq = 1'b1; ldAddr = 3'd2; ldData = 32'hBBBB0002;
    for (int i = 0; i < 8; i++) begin
      tick();
      expWb   = (i == 0) || (i == 4);
      expLd   = (i == 2) || (i == 6);
      expDeco = expWb ? 8'hFD : (expLd ? 8'hFB : 8'hFF);
      nTotal++;
      if ({wbAck8, ldAck8, deco8} !== {expWb, expLd, expDeco}) begin
        $display("FAIL round_robin[%0d]: wbAck=%b ldAck=%b deco=%h, required %b %b %h",
                 i, wbAck8, ldAck8, deco8, expWb, expLd, expDeco);
      end else nPass++;
      if (expWb || expLd) begin
        nTotal++;
        if (bus8 !== (expWb ? 32'hAAAA0001 : 32'hBBBB0002)) begin
          $display("FAIL round_robin_data[%0d]: bus=%h, required %h", i, bus8,
                   expWb ? 32'hAAAA0001 : 32'hBBBB0002);
        end else nPass++;
      end
      if (i == 6) begin
        wbReq = 1'b0; ldReq = 1'b0;
      end
    end
  endtask

  task automatic test_clear_sweep();
    logic       expBusy, expAck;
    logic [7:0] expClear, expDeco;
    doReset();
    clrAll = 1'b1;
    tick();
    clrAll = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      if (j == 4) begin
        ldReq = 1'b1; ldAddr = 3'd5; ldData = 32'h12345678;
      end
      expBusy  = (j <= 9);
      expClear = (j >= 2 && j <= 9) ? (8'hFF ^ (8'h01 << (j - 2))) : 8'hFF;
      expAck   = (j == 10);
      expDeco  = (j == 10) ? 8'hDF : 8'hFF;
      nTotal++;
      if ({busy8, clear8, ldAck8, deco8} !== {expBusy, expClear, expAck, expDeco}) begin
        $display("FAIL clear_sweep[%0d]: busy=%b clear=%h ldAck=%b deco=%h, required %b %h %b %h",
                 j, busy8, clear8, ldAck8, deco8, expBusy, expClear, expAck, expDeco);
      end else nPass++;
      if (j == 10) ldReq = 1'b0;
      if (j < 11) tick();
    end
  endtask

  task automatic test_clear_during_write();
    doReset();
    wbReq = 1'b1; wbAddr = 3'd6; wbData = 32'hCAFEF00D;
    tick();
    nTotal++;
    if ({wbAck8, deco8, bus8} !== {1'b1, 8'hBF, 32'hCAFEF00D}) begin
      $display("FAIL cdw_write: wbAck=%b deco=%h bus=%h, required 1 BF CAFEF00D", wbAck8, deco8, bus8);
    end else nPass++;
    wbReq = 1'b0;
    clrAll = 1'b1;
    ldReq = 1'b1; ldAddr = 3'd0; ldData = 32'h0000BEEF;
    tick();
    clrAll = 1'b0;
    nTotal++;
    if ({busy8, wbAck8, ldAck8, deco8, clear8} !== {3'b100, 8'hFF, 8'hFF}) begin
      $display("FAIL cdw_pending: busy=%b wbAck=%b ldAck=%b deco=%h clear=%h, required 1 0 0 FF FF",
               busy8, wbAck8, ldAck8, deco8, clear8);
    end else nPass++;
    tick();
    nTotal++;
    if ({busy8, ldAck8, deco8, clear8} !== {2'b10, 8'hFF, 8'hFF}) begin
      $display("FAIL cdw_no_grant: busy=%b ldAck=%b deco=%h clear=%h, required 1 0 FF FF",
               busy8, ldAck8, deco8, clear8);
    end else nPass++;
    tick();
    nTotal++;
    if ({busy8, ldAck8, clear8} !== {2'b10, 8'hFE}) begin
      $display("FAIL cdw_sweep_start: busy=%b ldAck=%b clear=%h, required 1 0 FE", busy8, ldAck8, clear8);
    end else nPass++;
    for (int k = 0; k < 8; k++) tick();
    nTotal++;
    if ({ldAck8, deco8, bus8, busy8} !== {1'b1, 8'hFE, 32'h0000BEEF, 1'b0}) begin
      $display("FAIL cdw_ld_after_sweep: ldAck=%b deco=%h bus=%h busy=%b, required 1 FE 0000BEEF 0",
               ldAck8, deco8, bus8, busy8);
    end else nPass++;
    ldReq = 1'b0;
    tick();
  endtask

  task automatic test_out_of_range();
    doReset();
    ldReq = 1'b1; ldAddr = 3'd7; ldData = 32'h55AA55AA;
    tick();
    nTotal++;
    if ({ldAck6, err6, deco6} !== {2'b11, 6'h3F}) begin
      $display("FAIL oor_dut6: ldAck=%b err=%b deco=%h, required 1 1 3F", ldAck6, err6, deco6);
    end else nPass++;
    nTotal++;
    if ({ldAck8, err8, deco8} !== {2'b10, 8'h7F}) begin
      $display("FAIL top_addr_dut8: ldAck=%b err=%b deco=%h, required 1 0 7F", ldAck8, err8, deco8);
    end else nPass++;
    ldReq = 1'b0;
    tick();
    nTotal++;
    if ({ldAck6, err6, deco6} !== {2'b00, 6'h3F}) begin
      $display("FAIL oor_err_pulse: ldAck=%b err=%b deco=%h, required 0 0 3F", ldAck6, err6, deco6);
    end else nPass++;
    ldReq = 1'b1; ldAddr = 3'd5; ldData = 32'h0F0F0F0F;
    tick();
    nTotal++;
    if ({ldAck6, err6, deco6, bus6} !== {2'b10, 6'h1F, 32'h0F0F0F0F}) begin
      $display("FAIL last_valid_dut6: ldAck=%b err=%b deco=%h bus=%h, required 1 0 1F 0F0F0F0F",
               ldAck6, err6, deco6, bus6);
    end else nPass++;
    ldReq = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    doReset();
    clrAll = 1'b1;
    tick();
    clrAll = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    nTotal++;
    if ({busy8, clear8} !== {1'b1, 8'hF7}) begin
      $display("FAIL ar_mid_sweep: busy=%b clear=%h, required 1 F7", busy8, clear8);
    end else nPass++;
    #2 rst = 1'b1;
    #1;
    nTotal++;
    if ({busy8, clear8, deco8, bus8, err8} !== {1'b0, 8'hFF, 8'hFF, 32'h0, 1'b0}) begin
      $display("FAIL ar_immediate: busy=%b clear=%h deco=%h bus=%h err=%b, required 0 FF FF 00000000 0",
               busy8, clear8, deco8, bus8, err8);
    end else nPass++;
    #1 rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      nTotal++;
      if ({busy8, clear8} !== {1'b0, 8'hFF}) begin
        $display("FAIL ar_no_resume[%0d]: busy=%b clear=%h, required 0 FF", k, busy8, clear8);
      end else nPass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_clear_sweep();
    test_clear_during_write();
    test_out_of_range();
    test_async_reset();
    @(negedge clk);
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule : tb_sc_regbank_write_ctrl
`default_nettype wire
